behav_counter_checker: RTL

Self-checking monitor for the loadable up/down counter, `behav_counter`. It observes the counter's control inputs and its `qd` output, and tracks a reference model of the count. Every cycle it compares the model against `qd` and reports mismatches, counts them and captures the first failure. It sits beside the counter in benches and in on-chip BIST wrappers as the reading end of the counter's control/data interface.

---
 rtl/behav_counter_checker_if.sv | 31 +++
 rtl/behav_counter_checker.sv | 134 +++++++++++++
 2 files changed

// File: rtl/behav_counter_checker_if.sv
// Control/data bundle between a behav_counter stimulus source and its checker.
// The master drives the counter controls and observed qd; the slave reports status.
interface behav_counter_checker_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 16
);
    logic                     en;
    logic                     clear;
    logic                     load;
    logic [DATA_WIDTH-1:0]    d;
    logic                     up_down;
    logic [DATA_WIDTH-1:0]    qd;
    logic                     clear_err;
    logic                     locked;
    logic                     mismatch;
    logic                     err_sticky;
    logic [ERR_CNT_WIDTH-1:0] err_count;
    logic [DATA_WIDTH-1:0]    first_exp;
    logic [DATA_WIDTH-1:0]    first_obs;
    logic [1:0]               state;

    modport master (
        output en, clear, load, d, up_down, qd, clear_err,
        input  locked, mismatch, err_sticky, err_count, first_exp, first_obs, state
    );

    modport slave (
        input  en, clear, load, d, up_down, qd, clear_err,
        output locked, mismatch, err_sticky, err_count, first_exp, first_obs, state
    );
endinterface

// File: rtl/behav_counter_checker.sv
// Reference-model checker for behav_counter: tracks the expected count and flags qd mismatches.
// Status outputs are registered (1-cycle latency); pure observer, never applies backpressure.
module behav_counter_checker #(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 16,
    parameter bit STOP_ON_ERROR = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    behav_counter_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    exp_q, exp_d, exp_next;
    logic                     mismatch_raw;
    logic                     mismatch_q, mismatch_d;
    logic                     sticky_q, sticky_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    first_exp_q, first_exp_d;
    logic [DATA_WIDTH-1:0]    first_obs_q, first_obs_d;

    // Counter rule as seen by the DUT: clear beats load beats count, modulo 2^DATA_WIDTH.
    always_comb begin
        exp_next = exp_q;
        if (bus.clear) begin
            exp_next = '0;
        end else if (bus.load) begin
            exp_next = bus.d;
        end else if (bus.up_down) begin
            exp_next = exp_q + DATA_WIDTH'(1);
        end else begin
            exp_next = exp_q - DATA_WIDTH'(1);
        end
    end

    assign mismatch_raw = (state_q == TRACK) && bus.en && (bus.qd != exp_q);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (bus.clear || bus.load) begin
                    state_d = TRACK;
                    exp_d   = exp_next;
                end
            end
            TRACK: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    exp_d   = '0;
                end else if (mismatch_raw && STOP_ON_ERROR) begin
                    state_d = HALT;
                end else begin
                    exp_d = exp_next;
                end
            end
            HALT: begin
                if (bus.clear_err) begin
                    state_d = SYNC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // clear_err wipes the old status first so a same-cycle mismatch is recorded as the first one.
    always_comb begin
        mismatch_d  = mismatch_raw;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        first_exp_d = first_exp_q;
        first_obs_d = first_obs_q;
        if (bus.clear_err) begin
            cnt_d       = '0;
            sticky_d    = 1'b0;
            first_exp_d = '0;
            first_obs_d = '0;
        end
        if (mismatch_raw) begin
            if (cnt_d != CNT_MAX) begin
                cnt_d = cnt_d + ERR_CNT_WIDTH'(1);
            end
            if (!sticky_d) begin
                first_exp_d = exp_q;
                first_obs_d = bus.qd;
            end
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            mismatch_q  <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            first_exp_q <= '0;
            first_obs_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            mismatch_q  <= mismatch_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            first_exp_q <= first_exp_d;
            first_obs_q <= first_obs_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.locked     = (state_q == TRACK);
    assign bus.mismatch   = mismatch_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_count  = cnt_q;
    assign bus.first_exp  = first_exp_q;
    assign bus.first_obs  = first_obs_q;
endmodule
